multiply_unit: RTL and testbench
================================

# multiply_unit

Iterative unsigned 32×32→64 multiplier with HI/LO result registers. It sits beside the ALU in the execute stage and takes the same register-file operands (srca, srcb). It replaces the single-cycle combinational multiply with a shift-add engine: one multiplier bit per cycle, a start/busy/done handshake, and mfhi/mflo-style readout.

## Interface
Parameters:
- WIDTH, 32: operand width; products are 2·WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- start  input  1  request a multiply; sampled only in IDLE or DONE.
- srca  input  WIDTH  multiplicand, captured on the accepting edge.
- srcb  input  WIDTH  multiplier, captured on the accepting edge.
- readhi  input  1  result select: 1 selects hi, 0 selects lo.
- result  output  WIDTH  combinational: readhi ? hi : lo.
- hi  output  WIDTH  upper half of the last completed product.
- lo  output  WIDTH  lower half of the last completed product.
- busy  output  1  high while an iteration is in progress (state RUN).
- done  output  1  one-cycle pulse: hi/lo hold a new product.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN.
  - On the accepting edge: mcand ← srca; prod ← {WIDTH'b0, srcb}; count ← WIDTH.
  - start=0 → stay in IDLE.
- RUN, every edge:
  - Compute upper = prod[2W-1:W] + (prod[0] ? mcand : 0) at WIDTH+1 bits so the carry is kept.
  - prod ← {upper, prod[W-1:1]}, i.e. the carry shifts into the MSB.
  - count ← count−1.
  - On the edge where count==1: also {hi,lo} ← the new prod value, then → DONE.
- DONE lasts one cycle; done=1 here.
  - start=1 → accept new operands exactly as in IDLE, → RUN (back-to-back).
  - start=0 → IDLE.
- start while in RUN is ignored. It is not queued.
- Unsigned arithmetic only; operands are never sign-extended.
- hi/lo hold their previous product during RUN, so reads during a multiply return the old result.
- reset, any state including mid-RUN: state=IDLE, hi=lo=0, prod=0, mcand=0, count=0. The in-flight product is discarded and done is not pulsed.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, result=0.
- start sampled high at the end of cycle 0 (IDLE/DONE) gives:
  - busy=1 in cycles 1..WIDTH;
  - last iteration at the end of cycle WIDTH;
  - done=1, busy=0 and hi/lo valid in cycle WIDTH+1.
- Latency from start edge to done: WIDTH+1 cycles (33 for WIDTH=32).
- Throughput: one product per WIDTH+1 cycles when start is held high or re-asserted in DONE.
- result changes in the same cycle as readhi (no register). It changes with hi/lo on the completing edge.
- reset and start both high on one edge: reset wins.
- busy and done are never high in the same cycle.

## Structure
- Shared package holds:
  - the state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - MUL_WIDTH=32;
  - the count width, clog2(WIDTH)+1.
- One natural sub-module: multiply_step, a combinational single shift-add iteration (prod, mcand → next prod). It can be unit-tested on its own.
- Top level holds the FSM, counter, operand registers and hi/lo registers.

## Test plan
- srca=3, srcb=5, start for one cycle → done in cycle 33; hi=0, lo=15; result=15 with readhi=0 and 0 with readhi=1.
- srca=0xFFFFFFFF, srcb=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Checks the carry path.
- srca=0x00010000, srcb=0x00010000 → hi=0x00000001, lo=0x00000000.
- Start 7×9, then pulse start with 2×2 in cycle 10 → the second start is ignored; done once with lo=63. During RUN, hi/lo still show the prior product.
- Start 0x1234×0x10, then assert reset in cycle 10 → next cycle busy=0, hi=lo=0; done never pulses. A fresh 6×7 afterwards gives lo=42.
- Hold start=1 with 4×5, then 0×0xDEADBEEF presented in the DONE cycle → done pulses in cycle 33 (lo=20) and again 33 cycles later (hi=lo=0), with busy re-asserted immediately after the first done.

Source files
------------

// File: rtl/multiply_unit_pkg.sv
// Shared definitions for the iterative shift-add multiplier: state encoding,
// default operand width and the iteration-counter width helper.
package multiply_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  localparam int MUL_WIDTH = 32;

  // Counter must hold the value WIDTH itself, hence the extra bit.
  function automatic int mul_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int MUL_CNT_W = mul_cnt_w(MUL_WIDTH);

endpackage

// File: rtl/multiply_unit_step.sv
// One shift-add iteration: add the multiplicand into the upper half when the
// current multiplier LSB is set, then shift the whole product right by one.
module multiply_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] next_prod
);

  logic [WIDTH:0] w_upper;

  // WIDTH+1 bits keep the carry; it becomes the new product MSB after the shift.
  always_comb begin
    w_upper   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    next_prod = {w_upper, prod[WIDTH-1:1]};
  end

endmodule

// File: rtl/multiply_unit.sv
// Iterative unsigned WIDTH x WIDTH -> 2*WIDTH multiplier with HI/LO result
// registers and a start/busy/done handshake; one multiplier bit per cycle.
module multiply_unit
  import multiply_unit_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             readhi,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = mul_cnt_w(WIDTH);

  mul_state_e         r_state;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] w_next_prod;

  multiply_step #(.WIDTH(WIDTH)) u_step (
    .prod      (r_prod),
    .mcand     (r_mcand),
    .next_prod (w_next_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_prod  <= '0;
      r_mcand <= '0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        // DONE accepts a new request exactly like IDLE for back-to-back issue.
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_mcand <= srca;
            r_prod  <= {{WIDTH{1'b0}}, srcb};
            r_count <= CW'(WIDTH);
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_prod  <= w_next_prod;
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_hi    <= w_next_prod[2*WIDTH-1:WIDTH];
            r_lo    <= w_next_prod[WIDTH-1:0];
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);
  assign hi     = r_hi;
  assign lo     = r_lo;
  assign result = readhi ? r_hi : r_lo;

endmodule

// File: tb/tb_multiply_unit.sv
// Directed-vector bench for multiply_unit: latency, products, readout mux,
// ignored start during RUN, mid-run reset and back-to-back issue.
module tb_multiply_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, readhi;
  logic [W-1:0] srca, srcb, result, hi, lo;
  logic         busy, done;

  int n_vec = 0;
  int n_bad = 0;

  multiply_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .srca(srca), .srcb(srcb),
    .readhi(readhi), .result(result), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands at a negedge; returns at the negedge of cycle 1.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    srca  = a;
    srcb  = b;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Caller is at cycle 1; returns the cycle in which done is seen (60 = timeout).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc, ndone;

  initial begin
    reset = 1'b1; start = 1'b0; readhi = 1'b0; srca = '0; srcb = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 3 x 5
    launch(32'd3, 32'd5, 1'b0);
    chk("t1_busy_c1", 64'(busy), 64'd1);
    wait_done(cyc);
    chk("t1_latency", 64'(cyc), 64'd33);
    chk("t1_busy_at_done", 64'(busy), 64'd0);
    chk("t1_hi", 64'(hi), 64'd0);
    chk("t1_lo", 64'(lo), 64'd15);
    readhi = 1'b0; #1;
    chk("t1_result_lo", 64'(result), 64'd15);
    readhi = 1'b1; #1;
    chk("t1_result_hi", 64'(result), 64'd0);
    readhi = 1'b0;
    @(negedge clk);
    chk("t1_done_pulse", 64'(done), 64'd0);

    // carry path
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(cyc);
    chk("t2_latency", 64'(cyc), 64'd33);
    chk("t2_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("t2_lo", 64'(lo), 64'h0000_0001);
    readhi = 1'b1; #1;
    chk("t2_result_hi", 64'(result), 64'hFFFF_FFFE);
    readhi = 1'b0;
    @(negedge clk);

    launch(32'h0001_0000, 32'h0001_0000, 1'b0);
    wait_done(cyc);
    chk("t3_hi", 64'(hi), 64'h1);
    chk("t3_lo", 64'(lo), 64'h0);
    @(negedge clk);

    // start during RUN ignored; old product visible until completion
    launch(32'd7, 32'd9, 1'b0);
    repeat (9) @(negedge clk);
    srca = 32'd2; srcb = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_hold_hi", 64'(hi), 64'h1);
    chk("t4_hold_lo", 64'(lo), 64'h0);
    chk("t4_busy", 64'(busy), 64'd1);
    cyc = 11;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_latency", 64'(cyc), 64'd33);
    chk("t4_lo", 64'(lo), 64'd63);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t4_extra_done", 64'(ndone), 64'd0);
    chk("t4_idle_busy", 64'(busy), 64'd0);

    // reset mid-RUN
    launch(32'h1234, 32'h10, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_hi", 64'(hi), 64'd0);
    chk("t5_lo", 64'(lo), 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t5_no_done", 64'(ndone), 64'd0);
    launch(32'd6, 32'd7, 1'b0);
    wait_done(cyc);
    chk("t5_latency", 64'(cyc), 64'd33);
    chk("t5_lo", 64'(lo), 64'd42);
    @(negedge clk);

    // reset and start on the same edge: reset wins
    reset = 1'b1; start = 1'b1; srca = 32'd3; srcb = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("t6_rst_wins_busy", 64'(busy), 64'd0);
    chk("t6_rst_wins_lo", 64'(lo), 64'd0);
    @(negedge clk);

    // back-to-back with start held
    launch(32'd4, 32'd5, 1'b1);
    wait_done(cyc);
    chk("t7_latency1", 64'(cyc), 64'd33);
    chk("t7_lo1", 64'(lo), 64'd20);
    srca = 32'd0; srcb = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    chk("t7_busy_again", 64'(busy), 64'd1);
    chk("t7_done_low", 64'(done), 64'd0);
    wait_done(cyc);
    chk("t7_latency2", 64'(cyc), 64'd33);
    chk("t7_hi2", 64'(hi), 64'd0);
    chk("t7_lo2", 64'(lo), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // busy and done are mutually exclusive by construction
  always @(negedge clk) begin
    if (busy && done) begin
      n_bad++;
      $display("FAIL busy_done_overlap: got busy=%0b done=%0b expected not both", busy, done);
    end
  end

endmodule
